apb_timer_slave: RTL and testbench
==================================

// Module: apb_timer_slave
// PURPOSE
//   APB slave placed directly downstream of the AHB-to-APB bridge. Decodes a 16-byte
//   register window: CTRL, LOAD, VALUE and STATUS. Contains a 32-bit down-counter
//   timer with an interrupt output and WAIT_STATES-cycle PREADY stretching. Serves as
//   the bridge's reference APB peripheral for wait-state and read-data path checks.
// PARAMETERS
//   ADDRWIDTH   16  PADDR width; offsets 0x0-0xF decoded, PADDR[ADDRWIDTH-1:4] must be 0
//   DATAWIDTH   32  PRDATA/PWDATA width (32 only)
//   WAIT_STATES 0   PREADY-low cycles inserted in each access phase (0..15)
// PORTS
//   PCLK      in   1          APB clock
//   PRESETn   in   1          async active-low reset
//   PSEL      in   1          slave select
//   PENABLE   in   1          access phase
//   PADDR     in   ADDRWIDTH  byte address; [1:0] ignored
//   PWRITE    in   1          1 = write
//   PWDATA    in   DATAWIDTH  write data
//   PRDATA    out  DATAWIDTH  read data; valid when PSEL&PENABLE&PREADY&!PWRITE, else 0
//   PREADY    out  1          transfer complete
//   PSLVERR   out  1          error response, see CONFIGURATION
//   TIMERINT  out  1          STATUS.INT & CTRL.INTEN
// BEHAVIOUR
//   Clock/reset: one clock PCLK; reset PRESETn is asynchronous, active-low.
//   Reset values: PRDATA=0, PREADY=1, PSLVERR=0, TIMERINT=0; CTRL=0, LOAD=0, VALUE=0, STATUS=0.
//   Map: 0x0 CTRL[2:0] RW (EN, INTEN, RELOAD); 0x4 LOAD RW; 0x8 VALUE RO;
//        0xC STATUS[0] INT, write-1-to-clear. Unused bits read 0.
//   FSM: IDLE -> SETUP on PSEL&!PENABLE -> ACCESS on the next edge.
//     - SETUP loads wcnt = WAIT_STATES.
//     - ACCESS: PREADY = (wcnt==0); wcnt decrements while nonzero.
//     - ACCESS -> IDLE when PREADY=1; goes straight to SETUP instead if PSEL&!PENABLE.
//     - PENABLE low while in ACCESS (protocol violation): abort to IDLE, no commit.
//     - Latency: WAIT_STATES=0 gives 2 cycles per transfer; each wait state adds 1 cycle.
//   Write commit: only in the cycle PSEL&PENABLE&PREADY&PWRITE; never during wait cycles.
//   Timer (evaluated every PCLK edge):
//     - Write to LOAD sets LOAD and VALUE to PWDATA; wins over that cycle's decrement.
//     - If EN and VALUE>1: VALUE-1.
//     - If EN and VALUE==1: VALUE<=0; STATUS.INT<=1.
//     - If EN and VALUE==0: RELOAD=1 gives VALUE<=LOAD; RELOAD=0 gives VALUE stays 0, CTRL.EN<=0.
//     - INT is set only on the 1->0 transition; LOAD=0 with RELOAD never interrupts.
//   Simultaneous INT set and W1C clear in one cycle: set wins, INT stays 1.
//   Reading VALUE returns the pre-edge value of the completing cycle.
//   Reset mid-transfer: all state to reset values immediately; the transfer is lost.
// CONFIGURATION
//   Macro APB_SLVERR_EN:
//     - Defined: PSLVERR=1 in the completing cycle for unmapped PADDR or a write to VALUE.
//       That write is discarded; a read of an unmapped address returns 0.
//     - Undefined: PSLVERR tied 0; such writes are silently ignored, reads return 0.
// TESTING
//   1 WAIT_STATES=0: write LOAD=0x10, read VALUE -> PREADY high in access; VALUE=0x10 (EN=0).
//   2 WAIT_STATES=3: write CTRL=0x1 -> PREADY low exactly 3 access cycles; EN commits
//     only in the 4th access cycle.
//   3 LOAD=3, CTRL=0x3 -> VALUE 3,2,1,0; INT and TIMERINT go high the cycle VALUE hits 0;
//     EN then clears.
//   4 LOAD=2, CTRL=0x7 -> INT every 3 cycles. Write STATUS=1 on the same edge INT sets
//     -> INT remains 1.
//   5 With APB_SLVERR_EN: write 0x8 and read 0x20 -> PSLVERR=1, VALUE unchanged, PRDATA=0.
//     Without it: PSLVERR=0.
//   6 PRESETn low during the ACCESS wait phase -> PREADY=1, regs 0 asynchronously;
//     the next transfer completes normally.

Source files
------------

// File: rtl/apb_timer_slave.sv
// -----------------------------------------------------------------------------
// apb_timer_slave
//   APB peripheral with a 16-byte register window and a 32-bit down-counter
//   timer with interrupt. The access phase can be stretched by WAIT_STATES
//   PREADY-low cycles.
//
//   Register map (word offsets, PADDR[1:0] ignored, PADDR[ADDRWIDTH-1:4] == 0):
//     0x0 CTRL   [2:0] RW  {RELOAD, INTEN, EN}
//     0x4 LOAD   RW        writing also loads VALUE
//     0x8 VALUE  RO        current count
//     0xC STATUS [0]  INT, write-1-to-clear
//
//   Ports:
//     PCLK, PRESETn        clock, asynchronous active-low reset
//     PSEL, PENABLE        APB select / access-phase strobe
//     PADDR, PWRITE        byte address, direction (1 = write)
//     PWDATA               write data
//     PRDATA               read data, 0 unless a read is completing
//     PREADY               transfer complete
//     PSLVERR              error response (unmapped address / write to VALUE)
//     TIMERINT             STATUS.INT & CTRL.INTEN
//
//   Build option: define APB_SLVERR_EN to drive PSLVERR on bad accesses;
//   without it PSLVERR is tied low and bad accesses are silently ignored.
// -----------------------------------------------------------------------------
module apb_timer_slave #(
  parameter int ADDRWIDTH   = 16,
  parameter int DATAWIDTH   = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic                 TIMERINT
);

  localparam logic [3:0] WAIT_INIT = WAIT_STATES[3:0];

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  state_t         state_q;
  logic [3:0]     wcnt_q;
  logic           pready_q;

  logic [2:0]           ctrl_q,  ctrl_d;
  logic [DATAWIDTH-1:0] load_q,  load_d;
  logic [DATAWIDTH-1:0] value_q, value_d;
  logic                 int_q,   int_d;
  logic                 int_set;

  logic       setup_ph;
  logic       xfer_done;
  logic       wr_en;
  logic       rd_en;
  logic       in_window;
  logic [1:0] offs;
  logic       wr_ctrl;
  logic       wr_load;
  logic       wr_status;
  logic       unused_addr;

  // The setup phase is recognised directly from the bus so that a transfer
  // with no wait states completes in two cycles: the edge closing the setup
  // cycle enters ACCESS with the wait counter already loaded.
  assign setup_ph = PSEL & ~PENABLE;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= 4'd0;
      pready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (setup_ph) begin
            state_q  <= ST_ACCESS;
            wcnt_q   <= WAIT_INIT;
            pready_q <= (WAIT_INIT == 4'd0);
          end
        end
        ST_ACCESS: begin
          if (PSEL && PENABLE) begin
            if (pready_q) begin
              state_q  <= ST_IDLE;
              pready_q <= 1'b1;
            end else begin
              wcnt_q   <= wcnt_q - 4'd1;
              pready_q <= (wcnt_q == 4'd1);
            end
          end else if (setup_ph) begin
            // Master restarted with a fresh setup phase: drop the old
            // transfer and track the new one rather than miss its access.
            state_q  <= ST_ACCESS;
            wcnt_q   <= WAIT_INIT;
            pready_q <= (WAIT_INIT == 4'd0);
          end else begin
            // PENABLE/PSEL dropped mid-access: abandon without committing.
            state_q  <= ST_IDLE;
            wcnt_q   <= 4'd0;
            pready_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          wcnt_q   <= 4'd0;
          pready_q <= 1'b1;
        end
      endcase
    end
  end

  assign PREADY = pready_q;

  assign xfer_done = (state_q == ST_ACCESS) & PSEL & PENABLE & pready_q;
  assign wr_en     = xfer_done &  PWRITE;
  assign rd_en     = xfer_done & ~PWRITE;

  assign in_window   = (PADDR[ADDRWIDTH-1:4] == '0);
  assign offs        = PADDR[3:2];
  assign unused_addr = ^PADDR[1:0];

  assign wr_ctrl   = wr_en & in_window & (offs == 2'd0);
  assign wr_load   = wr_en & in_window & (offs == 2'd1);
  assign wr_status = wr_en & in_window & (offs == 2'd3);

  always_comb begin
    PRDATA = '0;
    if (rd_en && in_window) begin
      case (offs)
        2'd0:    PRDATA = {{(DATAWIDTH-3){1'b0}}, ctrl_q};
        2'd1:    PRDATA = load_q;
        2'd2:    PRDATA = value_q;
        default: PRDATA = {{(DATAWIDTH-1){1'b0}}, int_q};
      endcase
    end
  end

`ifdef APB_SLVERR_EN
  logic bad_access;
  assign bad_access = ~in_window | (PWRITE & (offs == 2'd2));
  assign PSLVERR    = xfer_done & bad_access;
`else
  assign PSLVERR = 1'b0;
`endif

  // Timer next state. A LOAD write takes priority over the count step; a CTRL
  // write overrides the automatic EN clear of the same edge; an INT set
  // overrides a same-edge write-1-to-clear.
  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    value_d = value_q;
    int_d   = int_q;
    int_set = 1'b0;

    if (wr_load) begin
      load_d  = PWDATA;
      value_d = PWDATA;
    end else if (ctrl_q[0]) begin
      if (value_q > DATAWIDTH'(1)) begin
        value_d = value_q - DATAWIDTH'(1);
      end else if (value_q == DATAWIDTH'(1)) begin
        value_d = '0;
        int_set = 1'b1;
      end else if (ctrl_q[2]) begin
        value_d = load_q;
      end else begin
        ctrl_d[0] = 1'b0;
      end
    end

    if (wr_ctrl) begin
      ctrl_d = PWDATA[2:0];
    end
    if (wr_status && PWDATA[0]) begin
      int_d = 1'b0;
    end
    if (int_set) begin
      int_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q  <= 3'd0;
      load_q  <= '0;
      value_q <= '0;
      int_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      value_q <= value_d;
      int_q   <= int_d;
    end
  end

  assign TIMERINT = int_q & ctrl_q[1];

endmodule

// File: tb/tb_apb_timer_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_timer_slave
//   Two instances: u_dut0 (WAIT_STATES=0) and u_dut1 (WAIT_STATES=3), each on
//   its own bus. A behavioural timer model per instance advances on every
//   clock edge and supplies expected read data, PSLVERR and TIMERINT.
// -----------------------------------------------------------------------------
module tb_apb_timer_slave;

`ifdef APB_SLVERR_EN
  localparam bit SLVERR_ON = 1'b1;
`else
  localparam bit SLVERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [15:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic        tint    [2];

  apb_timer_slave #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAIT_STATES(0)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .TIMERINT(tint[0]));

  apb_timer_slave #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAIT_STATES(3)) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .TIMERINT(tint[1]));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // -1 for addresses outside the window, else register index 0..3
  function automatic int reg_of(input logic [15:0] a);
    if (a[15:4] != 12'h0) return -1;
    return int'(a[3:2]);
  endfunction

  // ---------------- behavioural model ----------------
  logic [2:0]  m_ctrl  [2];
  logic [31:0] m_load  [2];
  logic [31:0] m_value [2];
  logic        m_int   [2];

  // transfer committing at the next clock edge, per instance
  logic        cm_pend [2];
  logic        cm_wr   [2];
  logic [15:0] cm_addr [2];
  logic [31:0] cm_data [2];

  function automatic logic [31:0] model_read(input int k, input logic [15:0] a);
    case (reg_of(a))
      0:       return {29'h0, m_ctrl[k]};
      1:       return m_load[k];
      2:       return m_value[k];
      3:       return {31'h0, m_int[k]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input int k);
    int          r;
    bit          fire;
    bit          clr;
    logic [2:0]  nc;
    logic [31:0] nv;
    r    = (cm_pend[k] && cm_wr[k]) ? reg_of(cm_addr[k]) : -1;
    nc   = m_ctrl[k];
    nv   = m_value[k];
    fire = 1'b0;
    if (r == 1) begin
      m_load[k] = cm_data[k];
      nv        = cm_data[k];
    end else if (m_ctrl[k][0]) begin
      if (m_value[k] == 0) begin
        if (m_ctrl[k][2]) nv = m_load[k];
        else              nc[0] = 1'b0;
      end else begin
        nv   = m_value[k] - 1;
        fire = (m_value[k] == 1);
      end
    end
    if (r == 0) nc = cm_data[k][2:0];
    clr        = (r == 3) && cm_data[k][0];
    m_int[k]   = (m_int[k] && !clr) || fire;
    m_ctrl[k]  = nc;
    m_value[k] = nv;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_ctrl[k] = 3'h0; m_load[k] = 32'h0; m_value[k] = 32'h0; m_int[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_edge(k);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk("timerint_idle", tint[k], m_int[k] & m_ctrl[k][1]);
    end
  endtask

  task automatic apb(input int k, input bit wr, input logic [15:0] a,
                     input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit          exp_err;
    rd = 32'h0;
    @(posedge clk); #1;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
    @(posedge clk); #1;
    penable[k] = 1'b1;
    for (int i = 0; i <= ws_of(k); i++) begin
      @(negedge clk);
      chk("pready", pready[k], (i == ws_of(k)));
      chk("timerint", tint[k], m_int[k] & m_ctrl[k][1]);
      if (i == ws_of(k)) begin
        exp_rd  = wr ? 32'h0 : model_read(k, a);
        exp_err = SLVERR_ON && ((reg_of(a) < 0) || (wr && reg_of(a) == 2));
        chk("prdata", prdata[k], exp_rd);
        chk("pslverr", pslverr[k], exp_err);
        rd         = prdata[k];
        cm_pend[k] = 1'b1; cm_wr[k] = wr; cm_addr[k] = a; cm_data[k] = d;
      end else begin
        chk("prdata_wait", prdata[k], 32'h0);
      end
    end
    @(posedge clk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0; cm_pend[k] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] rd;
    logic [15:0] a;
    logic [31:0] d;
    int          k;
    int          n;

    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = 16'h0; pwdata[i] = 32'h0;
      cm_pend[i] = 1'b0; cm_wr[i] = 1'b0; cm_addr[i] = 16'h0; cm_data[i] = 32'h0;
    end

    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_pready",  pready[i],  1'b1);
      chk("rst_prdata",  prdata[i],  32'h0);
      chk("rst_pslverr", pslverr[i], 1'b0);
      chk("rst_tint",    tint[i],    1'b0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // zero-wait write LOAD then read VALUE with EN off
    apb(0, 1'b1, 16'h4, 32'h10, rd);
    apb(0, 1'b0, 16'h8, 32'h0, rd);
    chk("t1_value", rd, 32'h10);

    // 3 wait states: EN must not commit before the 4th access cycle
    apb(1, 1'b1, 16'h4, 32'd20, rd);
    apb(1, 1'b1, 16'h0, 32'h1, rd);
    apb(1, 1'b0, 16'h8, 32'h0, rd);
    chk("t2_value", rd, 32'd15);

    // one-shot countdown with interrupt, EN clears itself
    apb(0, 1'b1, 16'h4, 32'h3, rd);
    apb(0, 1'b1, 16'h0, 32'h3, rd);
    idle(8);
    apb(0, 1'b0, 16'h0, 32'h0, rd);
    chk("t3_ctrl", rd, 32'h2);
    apb(0, 1'b0, 16'hC, 32'h0, rd);
    chk("t3_status", rd, 32'h1);
    apb(0, 1'b0, 16'h8, 32'h0, rd);
    chk("t3_value", rd, 32'h0);

    // periodic reload; W1C landing on the same edge as the INT set
    apb(0, 1'b1, 16'h4, 32'h2, rd);
    apb(0, 1'b1, 16'h0, 32'h7, rd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_value[0] != 0 && n < 10);
    apb(0, 1'b1, 16'hC, 32'h1, rd);
    apb(0, 1'b0, 16'hC, 32'h0, rd);
    chk("t4_int_kept", rd, 32'h1);
    apb(0, 1'b1, 16'h0, 32'h0, rd);

    // bad accesses
    apb(0, 1'b1, 16'h8, 32'h55, rd);
    apb(0, 1'b0, 16'h20, 32'h0, rd);
    chk("t5_unmapped_rd", rd, 32'h0);
    apb(0, 1'b0, 16'h8, 32'h0, rd);
    apb(1, 1'b1, 16'h34, 32'h9, rd);

    // randomized traffic on both instances
    for (int it = 0; it < 80; it++) begin
      k = int'($urandom_range(0, 1));
      d = $urandom;
      case ($urandom_range(0, 9))
        0, 1: apb(k, 1'b1, 16'h0, 32'($urandom_range(0, 7)), rd);
        2:    apb(k, 1'b1, 16'h4, 32'($urandom_range(0, 6)), rd);
        3:    apb(k, 1'b1, 16'h4, d, rd);
        4:    apb(k, 1'b1, 16'hC, d, rd);
        5:    apb(k, 1'b1, 16'h8 | 16'($urandom_range(0, 3)), d, rd);
        6: begin
          a = 16'($urandom_range(1, 4095) << 4) | 16'($urandom_range(0, 15));
          apb(k, $urandom_range(0, 1) == 1, a, d, rd);
        end
        default: begin
          a = 16'($urandom_range(0, 3) << 2) | 16'($urandom_range(0, 3));
          apb(k, 1'b0, a, 32'h0, rd);
        end
      endcase
      idle(int'($urandom_range(0, 3)));
    end

    // async reset during the wait phase of a stretched write
    apb(1, 1'b1, 16'h4, 32'h77, rd);
    @(posedge clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 16'h4; pwdata[1] = 32'hABC;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(negedge clk);
    chk("t6_wait", pready[1], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pready", pready[1], 1'b1);
    chk("t6_rst_tint", tint[1], 1'b0);
    chk("t6_rst_prdata", prdata[1], 32'h0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    apb(1, 1'b0, 16'h4, 32'h0, rd);
    chk("t6_load_rst", rd, 32'h0);
    apb(1, 1'b0, 16'h0, 32'h0, rd);
    chk("t6_ctrl_rst", rd, 32'h0);
    apb(1, 1'b1, 16'h4, 32'h5A, rd);
    apb(1, 1'b0, 16'h4, 32'h0, rd);
    chk("t6_after", rd, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
